tte_flow_lookup_ctrl: RTL and testbench
=======================================

# tte_flow_lookup_ctrl

Initiator for the TTE flow-table hash bucket: it owns the bucket's search port (`se_*`) and write port (`hash_update`/`hash_clear`). It accepts header lookups from the frame parser and insert/delete/clear commands from management, computes the 12-bit bucket index, and serializes all bucket traffic. It issues single-cycle commands and returns a portmap or a miss/timeout indication upstream.

## Interface
- `LK_TIMEOUT`, 32: cycles to wait for `se_ack`/`se_nak`.
- `WR_TIMEOUT`, 32: cycles to wait for `reg_rst` after `hash_update`.
- `CLR_TIMEOUT`, 8192: cycles to wait for `reg_rst` after a clear or after reset.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `lk_valid` in 1, `lk_ready` out 1: lookup request handshake.
- `lk_dmac`, `lk_smac` in 48 each: lookup key.
- `rsp_valid` out 1: one-cycle lookup result strobe.
- `rsp_hit` out 1: entry matched.
- `rsp_timeout` out 1: bucket did not answer.
- `rsp_portmap` out 16: `se_result` on hit, else 0.
- `ins_valid` in 1, `ins_ready` out 1: insert/delete handshake.
- `ins_dmac`, `ins_smac` in 48 each; `ins_portmap` in 16.
- `ins_del` in 1: write the entry with valid=0.
- `ins_done` out 1: one-cycle completion strobe; `ins_err` out 1: valid with `ins_done`, set on timeout.
- `clr_req` in 1: pulse requesting a full-table clear; `clr_done` out 1: one-cycle completion strobe.
- `table_ready` out 1: high once the initial bucket clear has finished.
- `se_dmac`, `se_smac` out 48 each; `se_hash` out 12; `se_req` out 1.
- `se_ack`, `se_nak` in 1 each; `se_result` in 16.
- `hash_clear` out 1; `hash_update` out 1; `hash` out 12; `flow` out 120; `reg_rst` in 1.

## Operation
- Hash: x = dmac ^ {smac[23:0], smac[47:24]}; index = x[11:0]^x[23:12]^x[35:24]^x[47:36]. Lookup and insert use the same function.
- Flow word: [15:0] portmap, [63:16] dmac, [111:64] smac, [118:112] 0, [119] = ~ins_del.
- States:
  - INIT_WAIT: after reset the bucket self-clears; wait for `reg_rst`, then set `table_ready` and go to IDLE. On CLR_TIMEOUT, pulse `hash_clear` and go to CLR_WAIT.
  - IDLE: `lk_ready` = `ins_ready` = 1 only here, and only when no clear is pending. Priority is clear > insert > lookup.
  - A `clr_req` seen in any state sets a pending flag. It is serviced in IDLE: pulse `hash_clear`, go to CLR_WAIT.
  - Insert accept: register `hash` and `flow`, pulse `hash_update` for 1 cycle, go to WR_WAIT.
  - Lookup accept: register `se_dmac`, `se_smac`, `se_hash`, pulse `se_req` for 1 cycle, go to LK_WAIT.
  - LK_WAIT, on `se_ack`: `rsp_hit`=1, `rsp_portmap`=`se_result`.
  - LK_WAIT, on `se_nak`: `rsp_hit`=0, `rsp_portmap`=0.
  - LK_WAIT, on timeout: `rsp_timeout`=1, `rsp_hit`=0.
  - All LK_WAIT outcomes pulse `rsp_valid` and return to IDLE.
  - If `se_ack` and `se_nak` arrive together, `se_ack` wins.
  - WR_WAIT: `reg_rst` gives `ins_done`; timeout gives `ins_done` with `ins_err`=1. Return to IDLE.
  - CLR_WAIT: `reg_rst` or CLR_TIMEOUT gives `clr_done` and sets `table_ready`. Return to IDLE.
- Any `se_ack`, `se_nak` or `reg_rst` arriving outside the matching wait state is discarded.
- Reset values: all strobes and outputs are 0, `table_ready`=0, state INIT_WAIT.
  - Reset mid-operation abandons the transaction with no response strobe.
  - The timeout counter clears on every state entry.

## Timing
- Bucket commands (`se_req`, `hash_update`, `hash_clear`) are registered single-cycle pulses.
- Data outputs are stable from the pulse cycle until the next command.
- Accept cycle T: `se_req`=1 at T+1; bucket answers at T+6; `rsp_valid` at T+7. Lookup latency is 7 cycles and the next accept is possible at T+8.
- Insert accept at T: `hash_update` at T+1; `reg_rst` at T+3; `ins_done` at T+4.
- A timeout fires when the wait counter reaches its parameter. The response strobe follows in the next cycle.
- Throughput is one outstanding bucket operation; there is no pipelining.

## Test plan
- Reset, then a `reg_rst` pulse 4097 cycles later → `table_ready` rises the following cycle; `lk_ready`=0 before that.
- Insert dmac=48'h000000000001, smac=0, portmap=16'h0004 → `hash`=12'h001, `flow`=120'h80_000000000000_000000000001_0004; `ins_done` 4 cycles after accept with `ins_err`=0.
- Lookup with the same key and a bucket model returning `se_ack` with `se_result`=16'h0004 → `se_hash`=12'h001; `rsp_valid` at T+7 with `rsp_hit`=1, `rsp_portmap`=16'h0004.
- Lookup with the model answering `se_nak` → `rsp_hit`=0, `rsp_portmap`=0. With the model silent → `rsp_timeout`=1 after LK_TIMEOUT+1 cycles.
- `clr_req` during LK_WAIT plus `ins_valid` and `lk_valid` held → lookup completes, then `hash_clear` issues before the insert, then `clr_done`, then the insert, then the lookup.
- Assert `rst` during WR_WAIT → no `ins_done`; outputs return to 0 and state INIT_WAIT.

Source files
------------

// File: rtl/tte_flow_lookup_ctrl.sv
// Flow-table bucket initiator: hashes header/management keys, serializes lookups,
// inserts/deletes and table clears onto the bucket's search and write ports.
module tte_flow_lookup_ctrl #(
  parameter int LK_TIMEOUT  = 32,
  parameter int WR_TIMEOUT  = 32,
  parameter int CLR_TIMEOUT = 8192
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         lk_valid,
  output logic         lk_ready,
  input  logic [47:0]  lk_dmac,
  input  logic [47:0]  lk_smac,
  output logic         rsp_valid,
  output logic         rsp_hit,
  output logic         rsp_timeout,
  output logic [15:0]  rsp_portmap,
  input  logic         ins_valid,
  output logic         ins_ready,
  input  logic [47:0]  ins_dmac,
  input  logic [47:0]  ins_smac,
  input  logic [15:0]  ins_portmap,
  input  logic         ins_del,
  output logic         ins_done,
  output logic         ins_err,
  input  logic         clr_req,
  output logic         clr_done,
  output logic         table_ready,
  output logic [47:0]  se_dmac,
  output logic [47:0]  se_smac,
  output logic [11:0]  se_hash,
  output logic         se_req,
  input  logic         se_ack,
  input  logic         se_nak,
  input  logic [15:0]  se_result,
  output logic         hash_clear,
  output logic         hash_update,
  output logic [11:0]  hash,
  output logic [119:0] flow,
  input  logic         reg_rst
);

  localparam logic [2:0] S_INIT     = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_LK_WAIT  = 3'd2;
  localparam logic [2:0] S_WR_WAIT  = 3'd3;
  localparam logic [2:0] S_CLR_WAIT = 3'd4;
  localparam logic [2:0] S_RESP     = 3'd5;

  localparam logic [15:0] LK_TO_C  = 16'(LK_TIMEOUT);
  localparam logic [15:0] WR_TO_C  = 16'(WR_TIMEOUT);
  localparam logic [15:0] CLR_TO_C = 16'(CLR_TIMEOUT);

  function automatic logic [11:0] bucket_hash(input logic [47:0] dmac, input logic [47:0] smac);
    logic [47:0] x;
    x = dmac ^ {smac[23:0], smac[47:24]};
    return x[11:0] ^ x[23:12] ^ x[35:24] ^ x[47:36];
  endfunction

  logic [2:0]   state_r;
  logic [15:0]  cnt_r;
  logic         clr_pend_r;
  logic         rsp_valid_r, rsp_hit_r, rsp_timeout_r;
  logic [15:0]  rsp_portmap_r;
  logic         ins_done_r, ins_err_r, clr_done_r, table_ready_r;
  logic [47:0]  se_dmac_r, se_smac_r;
  logic [11:0]  se_hash_r, hash_r;
  logic         se_req_r, hash_clear_r, hash_update_r;
  logic [119:0] flow_r;
  logic         accept_s;

  // A pending clear blocks new requests so it is serviced ahead of them.
  assign accept_s    = (state_r == S_IDLE) && !clr_pend_r;
  assign lk_ready    = accept_s;
  assign ins_ready   = accept_s;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_hit     = rsp_hit_r;
  assign rsp_timeout = rsp_timeout_r;
  assign rsp_portmap = rsp_portmap_r;
  assign ins_done    = ins_done_r;
  assign ins_err     = ins_err_r;
  assign clr_done    = clr_done_r;
  assign table_ready = table_ready_r;
  assign se_dmac     = se_dmac_r;
  assign se_smac     = se_smac_r;
  assign se_hash     = se_hash_r;
  assign se_req      = se_req_r;
  assign hash_clear  = hash_clear_r;
  assign hash_update = hash_update_r;
  assign hash        = hash_r;
  assign flow        = flow_r;

  // Control FSM with registered strobes and bucket command/data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_INIT;
      cnt_r         <= 16'd0;
      clr_pend_r    <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_hit_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
      rsp_portmap_r <= 16'd0;
      ins_done_r    <= 1'b0;
      ins_err_r     <= 1'b0;
      clr_done_r    <= 1'b0;
      table_ready_r <= 1'b0;
      se_dmac_r     <= 48'd0;
      se_smac_r     <= 48'd0;
      se_hash_r     <= 12'd0;
      se_req_r      <= 1'b0;
      hash_clear_r  <= 1'b0;
      hash_update_r <= 1'b0;
      hash_r        <= 12'd0;
      flow_r        <= 120'd0;
    end else begin
      se_req_r      <= 1'b0;
      hash_clear_r  <= 1'b0;
      hash_update_r <= 1'b0;
      rsp_valid_r   <= 1'b0;
      ins_done_r    <= 1'b0;
      clr_done_r    <= 1'b0;
      cnt_r         <= cnt_r + 16'd1;
      clr_pend_r    <= clr_pend_r | clr_req;
      case (state_r)
        S_INIT: begin
          if (reg_rst) begin
            table_ready_r <= 1'b1;
            state_r       <= S_IDLE;
            cnt_r         <= 16'd0;
          end else if (cnt_r == CLR_TO_C) begin
            hash_clear_r <= 1'b1;
            state_r      <= S_CLR_WAIT;
            cnt_r        <= 16'd0;
          end else begin
            state_r <= S_INIT;
          end
        end
        S_IDLE: begin
          if (clr_pend_r) begin
            clr_pend_r   <= clr_req;
            hash_clear_r <= 1'b1;
            state_r      <= S_CLR_WAIT;
            cnt_r        <= 16'd0;
          end else if (ins_valid) begin
            hash_r        <= bucket_hash(ins_dmac, ins_smac);
            flow_r        <= {~ins_del, 7'd0, ins_smac, ins_dmac, ins_portmap};
            hash_update_r <= 1'b1;
            state_r       <= S_WR_WAIT;
            cnt_r         <= 16'd0;
          end else if (lk_valid) begin
            se_dmac_r <= lk_dmac;
            se_smac_r <= lk_smac;
            se_hash_r <= bucket_hash(lk_dmac, lk_smac);
            se_req_r  <= 1'b1;
            state_r   <= S_LK_WAIT;
            cnt_r     <= 16'd0;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_LK_WAIT: begin
          // ack outranks a simultaneous nak
          if (se_ack) begin
            rsp_valid_r   <= 1'b1;
            rsp_hit_r     <= 1'b1;
            rsp_timeout_r <= 1'b0;
            rsp_portmap_r <= se_result;
            state_r       <= S_RESP;
            cnt_r         <= 16'd0;
          end else if (se_nak || (cnt_r == LK_TO_C)) begin
            rsp_valid_r   <= 1'b1;
            rsp_hit_r     <= 1'b0;
            rsp_timeout_r <= ~se_nak;
            rsp_portmap_r <= 16'd0;
            state_r       <= S_RESP;
            cnt_r         <= 16'd0;
          end else begin
            state_r <= S_LK_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (reg_rst || (cnt_r == WR_TO_C)) begin
            ins_done_r <= 1'b1;
            ins_err_r  <= ~reg_rst;
            state_r    <= S_RESP;
            cnt_r      <= 16'd0;
          end else begin
            state_r <= S_WR_WAIT;
          end
        end
        S_CLR_WAIT: begin
          if (reg_rst || (cnt_r == CLR_TO_C)) begin
            clr_done_r    <= 1'b1;
            table_ready_r <= 1'b1;
            state_r       <= S_RESP;
            cnt_r         <= 16'd0;
          end else begin
            state_r <= S_CLR_WAIT;
          end
        end
        S_RESP: begin
          state_r <= S_IDLE;
          cnt_r   <= 16'd0;
        end
        default: begin
          state_r <= S_INIT;
          cnt_r   <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tte_flow_lookup_ctrl.sv
// Directed self-checking bench for tte_flow_lookup_ctrl with hand-computed expectations.
module tb_tte_flow_lookup_ctrl;

  logic         clk = 1'b0;
  logic         rst, lk_valid, lk_ready;
  logic [47:0]  lk_dmac, lk_smac;
  logic         rsp_valid, rsp_hit, rsp_timeout;
  logic [15:0]  rsp_portmap;
  logic         ins_valid, ins_ready;
  logic [47:0]  ins_dmac, ins_smac;
  logic [15:0]  ins_portmap;
  logic         ins_del, ins_done, ins_err, clr_req, clr_done, table_ready;
  logic [47:0]  se_dmac, se_smac;
  logic [11:0]  se_hash;
  logic         se_req, se_ack, se_nak;
  logic [15:0]  se_result;
  logic         hash_clear, hash_update;
  logic [11:0]  hash;
  logic [119:0] flow;
  logic         reg_rst;

  int n_cmp = 0;
  int n_bad = 0;

  tte_flow_lookup_ctrl dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_dmac(lk_dmac), .lk_smac(lk_smac),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_timeout(rsp_timeout), .rsp_portmap(rsp_portmap),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_dmac(ins_dmac), .ins_smac(ins_smac),
    .ins_portmap(ins_portmap), .ins_del(ins_del), .ins_done(ins_done), .ins_err(ins_err),
    .clr_req(clr_req), .clr_done(clr_done), .table_ready(table_ready),
    .se_dmac(se_dmac), .se_smac(se_smac), .se_hash(se_hash), .se_req(se_req),
    .se_ack(se_ack), .se_nak(se_nak), .se_result(se_result),
    .hash_clear(hash_clear), .hash_update(hash_update), .hash(hash), .flow(flow),
    .reg_rst(reg_rst)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 ack, 1 nak, 2 ack+nak, 3 silent; answer driven in cycle T+6
  task automatic do_lookup(input string tag, input logic [47:0] d, input logic [47:0] s,
                           input logic [11:0] exp_hash, input int kind, input logic [15:0] res,
                           input logic exp_hit, input logic exp_to, input logic [15:0] exp_pm,
                           input int exp_lat);
    logic early;
    chk({tag, "_ready"}, 120'(lk_ready), 120'd1);
    lk_valid = 1'b1; lk_dmac = d; lk_smac = s; se_result = res;
    tick;
    lk_valid = 1'b0;
    chk({tag, "_se_req"}, 120'(se_req), 120'd1);
    chk({tag, "_se_hash"}, 120'(se_hash), 120'(exp_hash));
    chk({tag, "_se_key"}, 120'({se_dmac, se_smac}), 120'({d, s}));
    early = 1'b0;
    for (int c = 2; c < exp_lat; c++) begin
      tick;
      se_ack = ((kind == 0) || (kind == 2)) && (c == 6);
      se_nak = ((kind == 1) || (kind == 2)) && (c == 6);
      if (rsp_valid !== 1'b0 || se_req !== 1'b0) early = 1'b1;
    end
    tick;
    se_ack = 1'b0; se_nak = 1'b0;
    chk({tag, "_early"}, 120'(early), 120'd0);
    chk({tag, "_rsp"}, 120'({rsp_valid, rsp_hit, rsp_timeout, rsp_portmap}),
        120'({1'b1, exp_hit, exp_to, exp_pm}));
    tick;
    chk({tag, "_after"}, 120'({rsp_valid, lk_ready}), 120'({1'b0, 1'b1}));
  endtask

  initial begin
    logic early;
    int c, rr_at, ack_at, t_rsp1, t_rsp2, t_hc, t_cd, t_hu, t_id, t_sr2, n_sr, n_rv, k;
    logic [11:0] hu_hash;

    rst = 1'b1; lk_valid = 1'b0; lk_dmac = 48'd0; lk_smac = 48'd0;
    ins_valid = 1'b0; ins_dmac = 48'd0; ins_smac = 48'd0; ins_portmap = 16'd0; ins_del = 1'b0;
    clr_req = 1'b0; se_ack = 1'b0; se_nak = 1'b0; se_result = 16'd0; reg_rst = 1'b0;

    // reset values
    tick; tick;
    chk("reset_strobes", 120'({lk_ready, ins_ready, rsp_valid, ins_done, clr_done, table_ready,
                               se_req, hash_clear, hash_update}), 120'd0);
    chk("reset_data", flow | 120'({hash, se_hash, rsp_portmap}), 120'd0);
    rst = 1'b0;

    // initial bucket self-clear
    early = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      if (lk_ready !== 1'b0 || table_ready !== 1'b0) early = 1'b1;
      tick;
    end
    chk("init_not_ready", 120'(early), 120'd0);
    reg_rst = 1'b1;
    tick;
    reg_rst = 1'b0;
    chk("init_table_ready", 120'({table_ready, lk_ready}), 120'({1'b1, 1'b1}));

    // insert with acknowledge
    chk("ins1_ready", 120'(ins_ready), 120'd1);
    ins_valid = 1'b1; ins_dmac = 48'h000000000001; ins_smac = 48'd0; ins_portmap = 16'h0004; ins_del = 1'b0;
    tick;
    ins_valid = 1'b0;
    chk("ins1_update", 120'({hash_update, ins_ready}), 120'({1'b1, 1'b0}));
    chk("ins1_hash", 120'(hash), 120'h001);
    chk("ins1_flow", flow, 120'h80_000000000000_000000000001_0004);
    tick;
    chk("ins1_pulse", 120'({hash_update, ins_done}), 120'd0);
    tick;
    reg_rst = 1'b1;
    chk("ins1_not_done", 120'(ins_done), 120'd0);
    tick;
    reg_rst = 1'b0;
    chk("ins1_done", 120'({ins_done, ins_err}), 120'({1'b1, 1'b0}));
    tick;
    chk("ins1_done_pulse", 120'(ins_done), 120'd0);

    // lookups: hit, miss, ack+nak, timeout
    do_lookup("lk_hit", 48'h000000000001, 48'd0, 12'h001, 0, 16'h0004, 1'b1, 1'b0, 16'h0004, 7);
    do_lookup("lk_nak", 48'h123456789abc, 48'hfedcba987654, 12'h4c4, 1, 16'hffff, 1'b0, 1'b0, 16'h0000, 7);
    do_lookup("lk_both", 48'h000000000abc, 48'd0, 12'habc, 2, 16'h0a5a, 1'b1, 1'b0, 16'h0a5a, 7);
    do_lookup("lk_tmo", 48'h000000000001, 48'd0, 12'h001, 3, 16'h0004, 1'b0, 1'b1, 16'h0000, 34);

    // stray bucket answers in IDLE are discarded
    se_ack = 1'b1; se_nak = 1'b1; reg_rst = 1'b1;
    tick;
    se_ack = 1'b0; se_nak = 1'b0; reg_rst = 1'b0;
    chk("stray_ignored", 120'({rsp_valid, ins_done, clr_done}), 120'd0);

    // delete with write timeout
    chk("del_ready", 120'(ins_ready), 120'd1);
    ins_valid = 1'b1; ins_dmac = 48'd0; ins_smac = 48'h000000000001; ins_portmap = 16'hbeef; ins_del = 1'b1;
    tick;
    ins_valid = 1'b0; ins_del = 1'b0;
    chk("del_hash", 120'({hash_update, hash}), 120'({1'b1, 12'h001}));
    chk("del_flow", flow, 120'h00_000000000001_000000000000_beef);
    early = 1'b0;
    for (int i = 2; i < 34; i++) begin
      tick;
      if (ins_done !== 1'b0) early = 1'b1;
    end
    tick;
    chk("del_tmo_early", 120'(early), 120'd0);
    chk("del_tmo_done", 120'({ins_done, ins_err}), 120'({1'b1, 1'b1}));
    tick;

    // clear during LK_WAIT with insert and lookup both held
    se_result = 16'h0004;
    chk("ord_lk_ready", 120'(lk_ready), 120'd1);
    lk_valid = 1'b1; lk_dmac = 48'h000000000001; lk_smac = 48'd0;
    ins_dmac = 48'h000000000abc; ins_smac = 48'd0; ins_portmap = 16'h0007;
    c = 0; rr_at = -1; ack_at = -1; n_sr = 0; n_rv = 0;
    t_rsp1 = -1; t_rsp2 = -1; t_hc = -1; t_cd = -1; t_hu = -1; t_id = -1; t_sr2 = -1;
    hu_hash = 12'd0;
    while (t_rsp2 < 0 && c < 300) begin
      tick;
      c++;
      reg_rst = (c == rr_at);
      se_ack  = (c == ack_at);
      clr_req = (c == 2);
      if (c == 1) ins_valid = 1'b1;
      if (se_req) begin
        n_sr++;
        ack_at = c + 5;
        if (n_sr == 2) begin t_sr2 = c; lk_valid = 1'b0; end
      end
      if (hash_clear && t_hc < 0) begin t_hc = c; rr_at = c + 2; end
      if (hash_update && t_hu < 0) begin t_hu = c; rr_at = c + 2; ins_valid = 1'b0; hu_hash = hash; end
      if (clr_done && t_cd < 0) t_cd = c;
      if (ins_done && t_id < 0) t_id = c;
      if (rsp_valid) begin
        n_rv++;
        if (n_rv == 1) t_rsp1 = c; else t_rsp2 = c;
      end
    end
    reg_rst = 1'b0; se_ack = 1'b0; clr_req = 1'b0; ins_valid = 1'b0; lk_valid = 1'b0;
    chk("ord_finished", 120'(t_rsp2 > 0), 120'd1);
    chk("ord_lk_then_clr", 120'((t_rsp1 > 0) && (t_hc > t_rsp1)), 120'd1);
    chk("ord_clr_done", 120'(t_cd > t_hc), 120'd1);
    chk("ord_ins_after_clr", 120'(t_hu > t_cd), 120'd1);
    chk("ord_ins_done", 120'(t_id > t_hu), 120'd1);
    chk("ord_lk_last", 120'((t_sr2 > t_id) && (t_rsp2 > t_sr2)), 120'd1);
    chk("ord_ins_hash", 120'(hu_hash), 120'habc);
    tick;

    // reset during WR_WAIT abandons the write
    chk("rstw_ready", 120'(ins_ready), 120'd1);
    ins_valid = 1'b1; ins_dmac = 48'h000000000abc; ins_smac = 48'd0; ins_portmap = 16'h0001;
    tick;
    ins_valid = 1'b0;
    chk("rstw_update", 120'(hash_update), 120'd1);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rstw_strobes", 120'({hash_update, ins_done, table_ready, ins_ready, lk_ready, rsp_valid,
                              rsp_hit, ins_err}), 120'd0);
    chk("rstw_data", flow | 120'({hash, se_hash, rsp_portmap}) | 120'(se_dmac), 120'd0);
    early = 1'b0; t_hc = -1; k = 0;
    while (t_hc < 0 && k < 9000) begin
      tick;
      k++;
      if (ins_done !== 1'b0) early = 1'b1;
      if (hash_clear) t_hc = k;
    end
    chk("rstw_no_done", 120'(early), 120'd0);
    chk("rstw_clr_tmo", 120'(t_hc), 120'd8193);
    chk("rstw_not_ready", 120'(table_ready), 120'd0);
    reg_rst = 1'b1;
    tick;
    reg_rst = 1'b0;
    chk("rstw_clr_done", 120'({clr_done, table_ready, ins_done}), 120'({1'b1, 1'b1, 1'b0}));
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
